// File: rtl/register_arbiter.sv
// Two-requester round-robin arbiter that serialises write/read accesses to one
// shared register and returns the register contents to the winning requester.
//
// state  | meaning
// IDLE   | no owner; arbitrate pending requests
// ACCESS | owner drives the register (load on write, hold on read)
// RESP   | done/rdata presented to the owner for one cycle
module register_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             wr_a,
    input  logic [WIDTH-1:0] wdata_a,
    output logic             gnt_a,
    output logic             done_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic             req_b,
    input  logic             wr_b,
    input  logic [WIDTH-1:0] wdata_b,
    output logic             gnt_b,
    output logic             done_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic [WIDTH-1:0] reg_r,
    output logic             reg_l,
    output logic             reg_e,
    input  logic [WIDTH-1:0] reg_q
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             lat_wr_q, lat_wr_d;
    logic [WIDTH-1:0] lat_data_q, lat_data_d;
    logic             winner;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        lat_wr_d   = lat_wr_q;
        lat_data_d = lat_data_q;
        // rr_ptr only breaks ties; a lone requester always wins
        winner     = (req_a && req_b) ? rr_ptr_q : req_b;
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    owner_d    = winner;
                    rr_ptr_d   = ~winner;
                    lat_wr_d   = winner ? wr_b : wr_a;
                    lat_data_d = winner ? wdata_b : wdata_a;
                    state_d    = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            lat_wr_q   <= 1'b0;
            lat_data_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            lat_wr_q   <= lat_wr_d;
            lat_data_q <= lat_data_d;
        end
    end

    assign gnt_a   = (state_q != IDLE) && !owner_q;
    assign gnt_b   = (state_q != IDLE) && owner_q;
    assign done_a  = (state_q == RESP) && !owner_q;
    assign done_b  = (state_q == RESP) && owner_q;
    assign rdata_a = done_a ? reg_q : '0;
    assign rdata_b = done_b ? reg_q : '0;

    assign reg_l = (state_q == ACCESS) && lat_wr_q;
    assign reg_e = reg_l;
    assign reg_r = reg_l ? lat_data_q : '0;

endmodule

// File: tb/tb_register_arbiter.sv
// Randomised bench for register_arbiter: requester processes drive traffic,
// a transaction-level model predicts service order, monitors compare responses.
module tb_register_arbiter;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_a, wr_a, req_b, wr_b;
    logic [WIDTH-1:0] wdata_a, wdata_b;
    logic             gnt_a, done_a, gnt_b, done_b;
    logic [WIDTH-1:0] rdata_a, rdata_b, reg_r;
    logic             reg_l, reg_e;
    logic [WIDTH-1:0] reg_q = '0;

    register_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .wr_a(wr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .done_a(done_a), .rdata_a(rdata_a),
        .req_b(req_b), .wr_b(wr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .done_b(done_b), .rdata_b(rdata_b),
        .reg_r(reg_r), .reg_l(reg_l), .reg_e(reg_e), .reg_q(reg_q)
    );

    always #5 clk = ~clk;

    // the shared register: loads r when both l and e are high
    always @(posedge clk) if (reg_l && reg_e) reg_q <= reg_r;

    typedef struct {
        bit               who;
        logic [WIDTH-1:0] data;
    } resp_t;

    resp_t            exp_q[$];
    logic [WIDTH-1:0] wr_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [WIDTH-1:0] ref_reg = '0;
    bit               ref_rr = 1'b0;

    bit               a_wr[8], b_wr[8];
    logic [WIDTH-1:0] a_dat[8], b_dat[8];
    int               lat_res[2];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one serviced access in the reference: writes update the register first
    task automatic model_access(input bit who, input bit wr, input logic [WIDTH-1:0] d);
        resp_t e;
        if (wr) begin
            ref_reg = d;
            wr_q.push_back(d);
        end
        e.who  = who;
        e.data = ref_reg;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        resp_t            e;
        logic [WIDTH-1:0] w;
        chk("done_overlap", {31'd0, done_a & done_b}, 0);
        chk("gnt_overlap", {31'd0, gnt_a & gnt_b}, 0);
        chk("l_eq_e", {31'd0, reg_l}, {31'd0, reg_e});
        if (done_a || done_b) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_done: got done_a=%0b done_b=%0b expected none", done_a, done_b);
            end else begin
                e = exp_q.pop_front();
                chk("resp_who", {31'd0, done_b}, {31'd0, e.who});
                chk("rdata", done_b ? rdata_b : rdata_a, e.data);
            end
        end
        if (!done_a) chk("rdata_a_quiet", rdata_a, 0);
        if (!done_b) chk("rdata_b_quiet", rdata_b, 0);
        if (reg_l) begin
            if (wr_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_load: got reg_r=%h expected no load", reg_r);
            end else begin
                w = wr_q.pop_front();
                chk("reg_r", reg_r, w);
            end
        end else begin
            chk("reg_r_quiet", reg_r, 0);
        end
    end

    // issues n accesses back to back, re-raising req as soon as the FSM is idle
    task automatic requester(input bit who, input int n);
        for (int i = 0; i < n; i++) begin
            int gc, lat;
            bit got;
            if (who) begin req_b = 1'b1; wr_b = b_wr[i]; wdata_b = b_dat[i]; end
            else     begin req_a = 1'b1; wr_a = a_wr[i]; wdata_a = a_dat[i]; end
            gc = 0; lat = 0; got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                lat++;
                if (who ? gnt_b : gnt_a) begin
                    gc++;
                    // latched values must be used, so scramble the port
                    if (who) begin wr_b = $urandom_range(0, 1); wdata_b = $urandom; end
                    else     begin wr_a = $urandom_range(0, 1); wdata_a = $urandom; end
                end
                if (who ? done_b : done_a) got = 1'b1;
            end
            chk(who ? "done_b_seen" : "done_a_seen", {31'd0, got}, 1);
            chk(who ? "gnt_b_cycles" : "gnt_a_cycles", gc, 2);
            lat_res[who] = lat;
            if (who) req_b = 1'b0; else req_a = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input int na, input int nb);
        int  ia, ib;
        bit  who;
        ia = 0; ib = 0;
        while (ia < na || ib < nb) begin
            if (ia < na && ib < nb) who = ref_rr;
            else                    who = (ia < na) ? 1'b0 : 1'b1;
            if (who) begin model_access(1'b1, b_wr[ib], b_dat[ib]); ib++; end
            else     begin model_access(1'b0, a_wr[ia], a_dat[ia]); ia++; end
            ref_rr = ~who;
        end
        fork
            requester(1'b0, na);
            requester(1'b1, nb);
        join
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8; i++) begin
            a_wr[i] = $urandom_range(0, 1); a_dat[i] = $urandom;
            b_wr[i] = $urandom_range(0, 1); b_dat[i] = $urandom;
        end
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
        wr_a = 1'b1; wr_b = 1'b1; wdata_a = $urandom; wdata_b = $urandom;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_gnt", {30'd0, gnt_a, gnt_b}, 0);
            chk("rst_done", {30'd0, done_a, done_b}, 0);
            chk("rst_reg_le", {30'd0, reg_l, reg_e}, 0);
            chk("rst_reg_r", reg_r, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
        @(posedge clk); #1;

        // contention right after reset: A has priority
        a_wr[0] = 1'b1; a_dat[0] = 32'hA; b_wr[0] = 1'b1; b_dat[0] = 32'hB;
        run(1, 1);
        chk("contend_lat_a", lat_res[0], 3);
        chk("contend_lat_b", lat_res[1], 6);

        a_wr[0] = 1'b1; a_dat[0] = 32'h5;
        run(1, 0);
        chk("single_lat_a", lat_res[0], 3);
        b_wr[0] = 1'b0; b_dat[0] = 32'hDEAD;
        run(0, 1);
        chk("read_lat_b", lat_res[1], 3);
        chk("reg_unchanged", reg_q, 32'h5);

        // fairness: three accesses each, continuously requested
        fill_random();
        run(3, 3);

        // reset lands at the end of A's write ACCESS cycle
        d = $urandom;
        req_a = 1'b1; wr_a = 1'b1; wdata_a = d;
        wr_q.push_back(d); ref_reg = d;
        @(negedge clk);
        @(negedge clk);
        chk("mid_gnt_a", {31'd0, gnt_a}, 1);
        chk("mid_reg_l", {31'd0, reg_l}, 1);
        rst = 1'b1; req_a = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt_a", {31'd0, gnt_a}, 0);
        chk("post_rst_done_a", {31'd0, done_a}, 0);
        rst = 1'b0; ref_rr = 1'b0;
        @(posedge clk); #1;
        b_wr[0] = 1'b0; b_dat[0] = $urandom;
        run(0, 1);
        chk("post_rst_reg", reg_q, d);

        for (int t = 0; t < 30; t++) begin
            int kind, gap;
            fill_random();
            kind = $urandom_range(0, 3);
            case (kind)
                0:       run(1, 0);
                1:       run(0, 1);
                2:       run(1, 1);
                default: run($urandom_range(1, 4), $urandom_range(1, 4));
            endcase
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
